// File: rtl/tlb_miss_walker.sv
// Fully associative TLB with an integrated page-table walk FSM.
// Hits answer from local entries; misses walk the page table and refill round-robin.
module tlb_miss_walker #(
  parameter int unsigned ENTRIES = 4,
  parameter int unsigned VPN_W   = 8,
  parameter int unsigned PPN_W   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [VPN_W-1:0] req_vpn,
  output logic             req_ready,
  output logic             resp_valid,
  output logic [PPN_W-1:0] resp_ppn,
  output logic             resp_hit,
  output logic             resp_fault,
  input  logic             flush,
  output logic             pt_req_valid,
  output logic [VPN_W-1:0] pt_req_vpn,
  input  logic             pt_resp_valid,
  input  logic [PPN_W-1:0] pt_resp_ppn,
  input  logic             pt_resp_fault
);

  localparam int unsigned IdxW = $clog2(ENTRIES);

  typedef enum logic [1:0] {StIdle, StLookup, StWalk, StRefill} state_e;

  state_e state_q, state_d;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [VPN_W-1:0]   tag_q  [ENTRIES];
  logic [PPN_W-1:0]   data_q [ENTRIES];
  logic [IdxW-1:0]    ptr_q;
  logic [VPN_W-1:0]   vpn_q;
  logic [PPN_W-1:0]   walk_ppn_q;
  logic               walk_fault_q;
  logic               resp_valid_q, resp_hit_q, resp_fault_q;
  logic [PPN_W-1:0]   resp_ppn_q;
  logic [VPN_W-1:0]   pt_req_vpn_q;

  logic             hit;
  logic [PPN_W-1:0] hit_ppn;

  // Scan from the top so the lowest matching index ends up winning.
  always_comb begin
    hit     = 1'b0;
    hit_ppn = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (valid_q[i] && (tag_q[i] == vpn_q)) begin
        hit     = 1'b1;
        hit_ppn = data_q[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (req_valid) state_d = StLookup;
      StLookup: state_d = hit ? StIdle : StWalk;
      StWalk:   if (pt_resp_valid) state_d = StRefill;
      StRefill: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Flush clears everything, but a same-cycle refill still lands its entry.
  always_comb begin
    valid_d = valid_q;
    if (flush) valid_d = '0;
    if (state_q == StRefill) valid_d[ptr_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      valid_q      <= '0;
      ptr_q        <= '0;
      vpn_q        <= '0;
      walk_ppn_q   <= '0;
      walk_fault_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_ppn_q   <= '0;
      pt_req_vpn_q <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      resp_valid_q <= 1'b0;
      if (state_q == StIdle && req_valid) vpn_q <= req_vpn;
      if (state_q == StLookup) begin
        if (hit) begin
          resp_valid_q <= 1'b1;
          resp_hit_q   <= 1'b1;
          resp_fault_q <= 1'b0;
          resp_ppn_q   <= hit_ppn;
        end else begin
          pt_req_vpn_q <= vpn_q;
        end
      end
      if (state_q == StWalk && pt_resp_valid) begin
        walk_ppn_q   <= pt_resp_ppn;
        walk_fault_q <= pt_resp_fault;
      end
      if (state_q == StRefill) begin
        resp_valid_q <= 1'b1;
        resp_hit_q   <= 1'b0;
        resp_fault_q <= walk_fault_q;
        resp_ppn_q   <= walk_ppn_q;
        ptr_q        <= ptr_q + IdxW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == StRefill) begin
      tag_q[ptr_q]  <= vpn_q;
      data_q[ptr_q] <= walk_ppn_q;
    end
  end

  assign req_ready    = (state_q == StIdle);
  assign pt_req_valid = (state_q == StWalk);
  assign pt_req_vpn   = pt_req_vpn_q;
  assign resp_valid   = resp_valid_q;
  assign resp_ppn     = resp_ppn_q;
  assign resp_hit     = resp_hit_q;
  assign resp_fault   = resp_fault_q;

endmodule

// File: tb/tb_tlb_miss_walker.sv
// Scoreboard bench for tlb_miss_walker with a fixed-latency page-table model.
module tb_tlb_miss_walker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic [7:0] req_vpn;
  logic       req_ready;
  logic       resp_valid;
  logic [5:0] resp_ppn;
  logic       resp_hit;
  logic       resp_fault;
  logic       flush;
  logic       pt_req_valid;
  logic [7:0] pt_req_vpn;
  logic       pt_resp_valid;
  logic [5:0] pt_resp_ppn;
  logic       pt_resp_fault;

  typedef struct {
    logic [5:0] ppn;
    logic       hit;
    logic       fault;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   walk_cnt = 0;
  int   ptcyc    = 0;

  tlb_miss_walker #(.ENTRIES(4), .VPN_W(8), .PPN_W(6)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_vpn      (req_vpn),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_ppn     (resp_ppn),
    .resp_hit     (resp_hit),
    .resp_fault   (resp_fault),
    .flush        (flush),
    .pt_req_valid (pt_req_valid),
    .pt_req_vpn   (pt_req_vpn),
    .pt_resp_valid(pt_resp_valid),
    .pt_resp_ppn  (pt_resp_ppn),
    .pt_resp_fault(pt_resp_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] ppn_of(input logic [7:0] v);
    return v[5:0] + 6'd1;
  endfunction

  // Page-table model: answers 3 cycles after it first sees a request.
  initial begin : pt_model
    logic [7:0] mvpn;
    int         cnt;
    bit         pend;
    pend          = 0;
    cnt           = 0;
    mvpn          = '0;
    pt_resp_valid = 1'b0;
    pt_resp_ppn   = '0;
    pt_resp_fault = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      pt_resp_valid = 1'b0;
      if (pt_req_valid) ptcyc++;
      if (pend) begin
        if (pt_req_valid) begin
          n_checks++;
          if (pt_req_vpn !== mvpn)
            $display("FAIL pt_vpn_stable: got %h want %h", pt_req_vpn, mvpn);
          else n_pass++;
        end
        cnt++;
        if (cnt == 3) begin
          pt_resp_valid = 1'b1;
          pt_resp_ppn   = ppn_of(mvpn);
          pt_resp_fault = (mvpn >= 8'hF0);
          pend          = 0;
        end
      end else if (pt_req_valid) begin
        pend = 1;
        cnt  = 1;
        mvpn = pt_req_vpn;
        walk_cnt++;
        n_checks++;
        if (pt_req_vpn !== req_vpn)
          $display("FAIL pt_req_vpn: got %h want %h", pt_req_vpn, req_vpn);
        else n_pass++;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (resp_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_resp: got resp_valid=1 want no response");
        end else begin
          e = sb.pop_front();
          n_checks++;
          if (resp_ppn !== e.ppn) $display("FAIL resp_ppn: got %h want %h", resp_ppn, e.ppn);
          else n_pass++;
          n_checks++;
          if (resp_hit !== e.hit) $display("FAIL resp_hit: got %b want %b", resp_hit, e.hit);
          else n_pass++;
          n_checks++;
          if (resp_fault !== e.fault)
            $display("FAIL resp_fault: got %b want %b", resp_fault, e.fault);
          else n_pass++;
        end
      end
    end
  end

  task automatic do_req(input logic [7:0] vpn, input logic exp_hit, input bit flush_mid);
    exp_t e;
    int   lat, w0, p0;
    bit   got;
    e.ppn   = ppn_of(vpn);
    e.hit   = exp_hit;
    e.fault = !exp_hit && (vpn >= 8'hF0);
    sb.push_back(e);
    w0 = walk_cnt;
    p0 = ptcyc;
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL req_ready_idle: got %b want 1", req_ready);
    else n_pass++;
    req_vpn   = vpn;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    got = 0;
    while (!got && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      flush = (flush_mid && lat == 3);
      got   = resp_valid;
    end
    flush = 1'b0;
    n_checks++;
    if (!got) $display("FAIL resp_timeout vpn %h: got none want resp_valid", vpn);
    else n_pass++;
    n_checks++;
    if (lat !== (exp_hit ? 2 : 6))
      $display("FAIL latency vpn %h: got %0d want %0d", vpn, lat, exp_hit ? 2 : 6);
    else n_pass++;
    n_checks++;
    if ((walk_cnt - w0) !== (exp_hit ? 0 : 1))
      $display("FAIL walk_count vpn %h: got %0d want %0d", vpn, walk_cnt - w0, exp_hit ? 0 : 1);
    else n_pass++;
    n_checks++;
    if ((ptcyc - p0) !== (exp_hit ? 0 : 3))
      $display("FAIL pt_hold_cycles vpn %h: got %0d want %0d", vpn, ptcyc - p0,
               exp_hit ? 0 : 3);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (resp_valid !== 1'b0) $display("FAIL resp_pulse vpn %h: got %b want 0", vpn, resp_valid);
    else n_pass++;
    n_checks++;
    if (resp_ppn !== e.ppn) $display("FAIL resp_hold vpn %h: got %h want %h", vpn, resp_ppn, e.ppn);
    else n_pass++;
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_vpn   = '0;
    flush     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({req_ready, resp_valid, resp_ppn, resp_hit, resp_fault, pt_req_valid, pt_req_vpn} !==
        {1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 8'd0})
      $display("FAIL reset_outputs: got rdy=%b rv=%b ppn=%h hit=%b flt=%b ptv=%b ptvpn=%h want 1/0/0/0/0/0/0",
               req_ready, resp_valid, resp_ppn, resp_hit, resp_fault, pt_req_valid, pt_req_vpn);
    else n_pass++;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_miss_then_hit;
    do_req(8'h05, 1'b0, 0);
    do_req(8'h05, 1'b1, 0);
  endtask

  task automatic test_fault;
    do_req(8'hF3, 1'b0, 0);
    do_req(8'hF3, 1'b1, 0);
  endtask

  task automatic test_replacement;
    for (int v = 1; v <= 4; v++) do_req(8'(v), 1'b0, 0);
    do_req(8'h45, 1'b0, 0);
    do_req(8'h02, 1'b1, 0);
    do_req(8'h01, 1'b0, 0);
  endtask

  task automatic test_flush;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    do_req(8'h02, 1'b0, 0);
  endtask

  task automatic test_flush_during_walk;
    do_req(8'h20, 1'b0, 1);
    do_req(8'h20, 1'b1, 0);
    do_req(8'h02, 1'b0, 0);
  endtask

  task automatic test_reset_mid_walk;
    req_vpn   = 8'h07;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (pt_req_valid !== 1'b1) $display("FAIL walk_started: got %b want 1", pt_req_valid);
    else n_pass++;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (pt_req_valid !== 1'b0) $display("FAIL async_drop: got %b want 0", pt_req_valid);
    else n_pass++;
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if ({req_ready, pt_req_valid} !== 2'b10)
      $display("FAIL post_reset_idle: got rdy=%b ptv=%b want 1/0", req_ready, pt_req_valid);
    else n_pass++;
    do_req(8'h05, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_miss_then_hit();
    test_fault();
    test_reset();
    test_replacement();
    test_flush();
    test_flush_during_walk();
    test_reset_mid_walk();
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (sb.size() !== 0) $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tlb_miss_walker.md
Name: tlb_miss_walker

Overview:
- Fully associative TLB with an integrated miss-handling FSM.
- Sits between the CPU translation request port and the page table, acting as the initiator of page-table lookups.
- Hits are answered from local entries. On a miss it issues a request/response walk to the page table, refills one entry, and returns the translation.
- Reports whether each translation came from the TLB or from a walk, and whether the page table raised a fault.

Parameters:
ENTRIES, 4, number of TLB entries (power of two, 2..16)
VPN_W, 8, virtual page number width
PPN_W, 6, physical page number width

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  CPU translation request valid
req_vpn  input  VPN_W  VPN to translate
req_ready  output  1  block can accept a request (high only in IDLE)
resp_valid  output  1  one-cycle pulse, translation result valid
resp_ppn  output  PPN_W  translated PPN
resp_hit  output  1  1 = TLB hit, 0 = served by walk
resp_fault  output  1  page table reported fault during walk
flush  input  1  invalidate all entries
pt_req_valid  output  1  page-table lookup request, held until response
pt_req_vpn  output  VPN_W  VPN sent to page table, stable while pt_req_valid
pt_resp_valid  input  1  page-table response valid (single-cycle pulse)
pt_resp_ppn  input  PPN_W  PPN returned by page table
pt_resp_fault  input  1  page was not resident; page table allocated it

Behaviour:
- Reset (async, rst_n=0):
  - All entry valid bits cleared; replacement pointer = 0; FSM = IDLE.
  - Outputs: req_ready=1, resp_valid=0, resp_ppn=0, resp_hit=0, resp_fault=0, pt_req_valid=0, pt_req_vpn=0.
- Entry = {valid, vpn[VPN_W-1:0], ppn[PPN_W-1:0]}.
- States: IDLE, LOOKUP, WALK, REFILL.
- IDLE:
  - req_ready=1.
  - On req_valid, latch req_vpn and go to LOOKUP. req_ready falls the next cycle.
- LOOKUP:
  - Parallel compare of latched VPN against all valid entries.
  - Hit: next edge drives resp_valid=1, resp_hit=1, resp_fault=0, resp_ppn=entry ppn, and goes to IDLE. Hit latency is 2 cycles from the accepting edge to the resp_valid edge.
  - Miss: go to WALK; pt_req_valid=1 and pt_req_vpn=latched VPN from the next edge.
  - Multiple matches cannot occur: refill only happens on a miss. If they do occur, the lowest index wins.
- WALK:
  - pt_req_valid held high and pt_req_vpn held stable until pt_resp_valid.
  - On pt_resp_valid, capture ppn and fault, drop pt_req_valid the same edge, and go to REFILL.
  - No timeout; the walk waits indefinitely.
- REFILL:
  - Write {1, vpn, ppn} to the entry at the replacement pointer.
  - Pointer increments modulo ENTRIES (round-robin). Invalid entries are not preferred; the pointer alone decides.
  - Same edge: resp_valid=1, resp_hit=0, resp_fault=captured fault, resp_ppn=captured ppn. Then go to IDLE.
- resp_valid is high exactly one cycle per accepted request. resp_ppn, resp_hit and resp_fault hold their last values afterwards.
- flush:
  - Clears all valid bits on the next edge in any state. The replacement pointer is not reset.
  - If flush and a REFILL write happen in the same cycle, the refill write wins for its entry; all other entries are cleared.
  - flush does not abort an in-flight walk.
- req_valid outside IDLE is ignored, since req_ready=0.
- pt_resp_valid outside WALK is ignored.
- Reset mid-walk: pt_req_valid drops immediately (asynchronously) and no response is produced. A late pt_resp_valid after reset is ignored.

Test Plan:
- Bench page-table model returns PPN = (VPN mod 64)+1 with a 3-cycle delay and fault=1 for VPN ≥ 0xF0.
- Reset, then request VPN 0x05 → pt_req_vpn=0x05 held 3 cycles; resp_valid with resp_ppn=0x06, resp_hit=0, resp_fault=0.
- Repeat VPN 0x05 → no pt_req_valid; resp_valid 2 cycles after acceptance with resp_ppn=0x06, resp_hit=1.
- Request VPN 0xF3 → resp_ppn=0x34, resp_hit=0, resp_fault=1. Re-request 0xF3 → resp_hit=1, resp_fault=0.
- Fill 4 entries (0x01, 0x02, 0x03, 0x04), then 0x45 → entry 0 replaced. Re-request 0x01 → miss and walk; 0x02 → hit with PPN 0x03.
- Assert flush one cycle, then request 0x02 → miss, walk issued, resp_ppn=0x03. Also assert flush during a WALK → the walk completes and only the refilled entry is valid.
- Drop rst_n while pt_req_valid=1 → pt_req_valid=0 immediately, no resp_valid. The model's late pt_resp_valid is ignored, and the next request 0x05 misses.
